// File: rtl/microwave_pkg.sv
// Shared types and constants for the magnetron PWM duty monitor.
// Holds the monitor FSM encoding and small duty arithmetic helpers.
package microwave_pkg;

  localparam int unsigned PWM_PERIOD_MAX = 100;
  localparam int unsigned DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'd100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } monitor_state_t;

  // Commanded duty above full scale means full on.
  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] d
  );
    return (d > DUTY_FULL) ? DUTY_FULL : d;
  endfunction

  // Unsigned distance, larger minus smaller, never wraps.
  function automatic logic [DUTY_W-1:0] abs_diff(
    input logic [DUTY_W-1:0] a,
    input logic [DUTY_W-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pwm_window_counter.sv
// Gapless fixed-length window counter for the duty monitor.
// Counts cycles and high samples; flags the last cycle of each window.
module pwm_window_counter
  import microwave_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = PWM_PERIOD_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              pwm_in,
  output logic              window_end,
  output logic [DUTY_W-1:0] final_cnt
);

  localparam int unsigned CW = $clog2(PWM_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PWM_PERIOD - 1);

  logic [CW-1:0]     win_cnt_q;
  logic [CW-1:0]     win_cnt_d;
  logic [DUTY_W-1:0] hi_cnt_q;
  logic [DUTY_W-1:0] hi_cnt_d;

  // The sample taken on the last cycle still belongs to the window.
  assign final_cnt  = hi_cnt_q + DUTY_W'(pwm_in);
  assign window_end = ~clr & (win_cnt_q == LAST);

  // Advance the window, restart right after its last cycle.
  always_comb begin
    win_cnt_d = win_cnt_q + CW'(1);
    hi_cnt_d  = final_cnt;
    if (clr || window_end) begin
      win_cnt_d = '0;
      hi_cnt_d  = '0;
    end
  end

  // Window counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q <= '0;
      hi_cnt_q  <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_duty_monitor.sv
// Receive-side duty checker for the magnetron PWM drive.
// Recovers duty per window, compares to command, raises sticky fault.
module pwm_duty_monitor
  import microwave_pkg::*;
#(
  parameter int unsigned PWM_PERIOD    = PWM_PERIOD_MAX,
  parameter int unsigned TOLERANCE     = 2,
  parameter int unsigned FAULT_WINDOWS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pwm_in,
  input  logic [DUTY_W-1:0] expected_duty,
  input  logic              fault_clr,
  output logic [DUTY_W-1:0] measured_duty,
  output logic              duty_valid,
  output logic              mismatch,
  output logic              fault
);

  localparam logic [DUTY_W-1:0] TOL = DUTY_W'(TOLERANCE);
  localparam logic [3:0] FW = 4'(FAULT_WINDOWS);
  localparam logic [3:0] RUN_MAX = 4'hF;

  monitor_state_t state_q;
  monitor_state_t state_d;

  logic [DUTY_W-1:0] exp_q;
  logic [DUTY_W-1:0] exp_d;
  logic [DUTY_W-1:0] meas_q;
  logic [DUTY_W-1:0] meas_d;
  logic              valid_q;
  logic              valid_d;
  logic              mis_q;
  logic              mis_d;
  logic              fault_q;
  logic              fault_d;
  logic [3:0]        run_q;
  logic [3:0]        run_d;

  logic              exp_chg;
  logic              cnt_clr;
  logic              win_end;
  logic              meas_end;
  logic [DUTY_W-1:0] final_cnt;
  logic [DUTY_W-1:0] exp_lim;
  logic [DUTY_W-1:0] diff;
  logic              out_tol;
  logic [3:0]        run_inc;
  logic              set_fault;

  // A new command restarts the settle window from scratch.
  assign exp_chg = (state_q != IDLE) & enable &
                   (expected_duty != exp_q);

  assign cnt_clr = (state_q == IDLE) | ~enable | exp_chg;

  pwm_window_counter #(
    .PWM_PERIOD (PWM_PERIOD)
  ) u_win (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .pwm_in     (pwm_in),
    .window_end (win_end),
    .final_cnt  (final_cnt)
  );

  assign meas_end = (state_q == MEASURE) & win_end;
  assign exp_lim  = clamp_duty(exp_q);
  assign diff     = abs_diff(final_cnt, exp_lim);
  assign out_tol  = diff > TOL;
  assign run_inc  = (run_q == RUN_MAX) ? run_q : run_q + 4'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enable low dominates, then command change.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = SETTLE;
      end
      SETTLE: begin
        if (!enable)      state_d = IDLE;
        else if (exp_chg) state_d = SETTLE;
        else if (win_end) state_d = MEASURE;
      end
      MEASURE: begin
        if (!enable)      state_d = IDLE;
        else if (exp_chg) state_d = SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window results, mismatch run length and fault flag.
  always_comb begin
    exp_d     = exp_q;
    meas_d    = meas_q;
    valid_d   = 1'b0;
    mis_d     = mis_q;
    run_d     = run_q;
    fault_d   = fault_q;
    set_fault = 1'b0;
    if (state_q == IDLE || exp_chg) begin
      exp_d = expected_duty;
    end
    if (state_q != IDLE && !enable) begin
      mis_d = 1'b0;
      run_d = '0;
    end else if (exp_chg) begin
      run_d = '0;
    end else if (meas_end) begin
      meas_d  = final_cnt;
      valid_d = 1'b1;
      mis_d   = out_tol;
      if (out_tol) begin
        run_d     = run_inc;
        set_fault = run_inc >= FW;
      end else begin
        run_d = '0;
      end
    end
    if (fault_clr) begin
      run_d   = '0;
      fault_d = 1'b0;
    end
    if (set_fault) begin
      fault_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q   <= '0;
      meas_q  <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      run_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      meas_q  <= meas_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      run_q   <= run_d;
      fault_q <= fault_d;
    end
  end

  assign measured_duty = meas_q;
  assign duty_valid    = valid_q;
  assign mismatch      = mis_q;
  assign fault         = fault_q;

endmodule
